regfile_wb_buffer: RTL and testbench

Writeback buffer between the ALU and memory result producers and the register file's single write port. It accepts up to two results per cycle, queues them in order, and drains one per cycle into the register file. It also provides operand bypass for in-flight results, because the register file itself does not bypass. Writes to R0 are discarded on entry.

---
 rtl/regfile_wb_buffer_pkg.sv | 14 +
 rtl/regfile_wb_buffer_if.sv | 48 ++++
 rtl/regfile_wb_buffer_bypass.sv | 45 ++++
 rtl/regfile_wb_buffer.sv | 98 +++++++++
 tb/tb_regfile_wb_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_buffer_pkg
// Description : Shared core widths and constants for the writeback buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_buffer_pkg;

    localparam int c_REG_W  = 4;
    localparam int c_DATA_W = 16;
    localparam logic [c_REG_W-1:0] c_R0 = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_buffer_if
// Description : Producer, register-file and bypass signals of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_buffer_if #(
    parameter int DEPTH = 4
) ();
    import regfile_wb_buffer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                mem_valid;
    logic [c_REG_W-1:0]  mem_dst;
    logic [c_DATA_W-1:0] mem_data;
    logic                alu_valid;
    logic [c_REG_W-1:0]  alu_dst;
    logic [c_DATA_W-1:0] alu_data;
    logic                in_ready;
    logic                rf_hold;
    logic                rf_we;
    logic [c_REG_W-1:0]  rf_dst;
    logic [c_DATA_W-1:0] rf_data;
    logic [c_REG_W-1:0]  byp_src1;
    logic [c_REG_W-1:0]  byp_src2;
    logic                byp_hit1;
    logic                byp_hit2;
    logic [c_DATA_W-1:0] byp_data1;
    logic [c_DATA_W-1:0] byp_data2;
    logic [CNT_W-1:0]    count;

    modport master (
        output mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
        output rf_hold, byp_src1, byp_src2,
        input  in_ready, rf_we, rf_dst, rf_data,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2, count
    );

    modport slave (
        input  mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
        input  rf_hold, byp_src1, byp_src2,
        output in_ready, rf_we, rf_dst, rf_data,
        output byp_hit1, byp_hit2, byp_data1, byp_data2, count
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_buffer_bypass.sv
`default_nettype none
// ============================================================================
// Module      : wb_bypass_match
// Description : Youngest-match search of one read register over queued entries.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bypass_match
    import regfile_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic [$clog2(DEPTH)-1:0]            head,
    input  wire logic [$clog2(DEPTH):0]              count,
    input  wire logic [DEPTH-1:0][c_REG_W-1:0]       dsts,
    input  wire logic [DEPTH-1:0][c_DATA_W-1:0]      datas,
    input  wire logic [c_REG_W-1:0]                  src,
    output logic                                     hit,
    output logic [c_DATA_W-1:0]                      data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                w_hit;
    logic [c_DATA_W-1:0] w_data;
    logic [PTR_W-1:0]    w_idx;

    // Walk from oldest to youngest so the last match overrides earlier ones.
    always_comb begin
        w_hit  = 1'b0;
        w_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (src != c_R0) && (dsts[w_idx] == src)) begin
                w_hit  = 1'b1;
                w_data = datas[w_idx];
            end
        end
    end

    assign hit  = w_hit;
    assign data = w_data;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_buffer
// Description : Two-in, one-out in-order writeback queue with operand bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_buffer
    import regfile_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_wb_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][c_REG_W-1:0]  r_dst;
    logic [DEPTH-1:0][c_DATA_W-1:0] r_data;
    logic [DEPTH-1:0]               r_vld;
    logic [PTR_W-1:0]               r_head;
    logic [PTR_W-1:0]               r_tail;
    logic [CNT_W-1:0]               r_count;

    logic             w_in_ready;
    logic             w_mem_enq;
    logic             w_alu_enq;
    logic [1:0]       w_enq_n;
    logic [PTR_W-1:0] w_alu_slot;
    logic             w_deq;

    assign w_in_ready = !rst && (r_count <= CNT_W'(DEPTH - 2));
    assign w_mem_enq  = bus.mem_valid && w_in_ready && (bus.mem_dst != c_R0);
    assign w_alu_enq  = bus.alu_valid && w_in_ready && (bus.alu_dst != c_R0);
    assign w_enq_n    = {1'b0, w_mem_enq} + {1'b0, w_alu_enq};
    // MEM is the older instruction, so ALU lands behind it when both enter.
    assign w_alu_slot = r_tail + PTR_W'(w_mem_enq);
    // Reset also blocks the drain so discarded entries never reach the file.
    assign w_deq      = !rst && (r_count != '0) && !bus.rf_hold;

    assign bus.in_ready = w_in_ready;
    assign bus.rf_we    = w_deq;
    assign bus.rf_dst   = r_vld[r_head] ? r_dst[r_head]  : c_R0;
    assign bus.rf_data  = r_vld[r_head] ? r_data[r_head] : '0;
    assign bus.count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (w_mem_enq) r_vld[r_tail]     <= 1'b1;
            if (w_alu_enq) r_vld[w_alu_slot] <= 1'b1;
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_count <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_enq) begin
            r_dst[r_tail]  <= bus.mem_dst;
            r_data[r_tail] <= bus.mem_data;
        end
        if (w_alu_enq) begin
            r_dst[w_alu_slot]  <= bus.alu_dst;
            r_data[w_alu_slot] <= bus.alu_data;
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
        .head  (r_head),
        .count (r_count),
        .dsts  (r_dst),
        .datas (r_data),
        .src   (bus.byp_src1),
        .hit   (bus.byp_hit1),
        .data  (bus.byp_data1)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
        .head  (r_head),
        .count (r_count),
        .dsts  (r_dst),
        .datas (r_data),
        .src   (bus.byp_src2),
        .hit   (bus.byp_hit2),
        .data  (bus.byp_data2)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_buffer
// Description : Directed self-checking bench for regfile_wb_buffer (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_buffer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    regfile_wb_buffer_if #(.DEPTH(4)) bus ();

    regfile_wb_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_valid = 1'b0;
        bus.mem_dst   = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_dst   = '0;
        bus.alu_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int got;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle_inputs();
        bus.rf_hold  = 1'b0;
        bus.byp_src1 = 4'd3;
        bus.byp_src2 = 4'd0;
        step();
        step();

        // reset state
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_rf_we",    bus.rf_we,    0);
        chk("rst_count",    bus.count,    0);
        chk("rst_rf_dst",   bus.rf_dst,   0);
        chk("rst_rf_data",  bus.rf_data,  0);
        chk("rst_hit1",     bus.byp_hit1, 0);
        chk("rst_data1",    bus.byp_data1, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_dst = 4'd3; bus.alu_data = 16'h1234;
        step();
        idle_inputs();
        #1;
        chk("alu_rf_we",   bus.rf_we,   1);
        chk("alu_rf_dst",  bus.rf_dst,  3);
        chk("alu_rf_data", bus.rf_data, 16'h1234);
        chk("alu_count",   bus.count,   1);
        chk("alu_hit1",    bus.byp_hit1, 1);
        chk("alu_data1",   bus.byp_data1, 16'h1234);
        step();
        chk("alu_count_0", bus.count, 0);
        chk("alu_we_0",    bus.rf_we, 0);

        // dual accept to the same register
        bus.byp_src1 = 4'd5;
        bus.mem_valid = 1'b1; bus.mem_dst = 4'd5; bus.mem_data = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_dst = 4'd5; bus.alu_data = 16'hBBBB;
        #1;
        chk("dual_no_early_byp", bus.byp_hit1, 0);
        step();
        idle_inputs();
        #1;
        chk("dual_count",   bus.count,     2);
        chk("dual_byp",     bus.byp_data1, 16'hBBBB);
        chk("dual_wr1_we",  bus.rf_we,     1);
        chk("dual_wr1",     bus.rf_data,   16'hAAAA);
        step();
        chk("dual_wr2_we",  bus.rf_we,     1);
        chk("dual_wr2",     bus.rf_data,   16'hBBBB);
        chk("dual_byp2",    bus.byp_data1, 16'hBBBB);
        step();
        chk("dual_count_0", bus.count,    0);
        chk("dual_hit_0",   bus.byp_hit1, 0);

        // R0 drop
        bus.byp_src1 = 4'd0;
        bus.alu_valid = 1'b1; bus.alu_dst = 4'd0; bus.alu_data = 16'hFFFF;
        step();
        idle_inputs();
        #1;
        chk("r0_count", bus.count,    0);
        chk("r0_we",    bus.rf_we,    0);
        chk("r0_hit",   bus.byp_hit1, 0);

        // fill under rf_hold
        bus.rf_hold = 1'b1;
        bus.byp_src2 = 4'd2;
        bus.mem_valid = 1'b1; bus.mem_dst = 4'd1; bus.mem_data = 16'h0001;
        bus.alu_valid = 1'b1; bus.alu_dst = 4'd2; bus.alu_data = 16'h0002;
        step();
        chk("fill_count2", bus.count,    2);
        chk("fill_ready2", bus.in_ready, 1);
        bus.mem_dst = 4'd3; bus.mem_data = 16'h0003;
        bus.alu_dst = 4'd4; bus.alu_data = 16'h0004;
        step();
        bus.mem_dst = 4'd6; bus.mem_data = 16'h0666;
        bus.alu_dst = 4'd2; bus.alu_data = 16'h0777;
        #1;
        chk("fill_count4", bus.count,    4);
        chk("fill_ready4", bus.in_ready, 0);
        chk("fill_hold_we", bus.rf_we,   0);
        chk("fill_byp2",   bus.byp_data2, 16'h0002);
        step();
        chk("fill_ignored", bus.count, 4);
        idle_inputs();
        bus.rf_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("fill_drain_we",  bus.rf_we,   1);
            chk("fill_drain_dat", bus.rf_data, i);
            step();
        end
        chk("fill_empty", bus.count, 0);

        // wrap-around with alternating hold
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            bus.rf_hold   = cyc[0];
            bus.alu_valid = (sent < 10);
            bus.alu_dst   = 4'(sent + 1);
            bus.alu_data  = 16'(16'hC000 + sent);
            #1;
            if (bus.rf_we) begin
                chk("wrap_dst",  bus.rf_dst,  got + 1);
                chk("wrap_data", bus.rf_data, 16'hC000 + got);
                got++;
            end
            if (bus.alu_valid && bus.in_ready) sent++;
            step();
        end
        idle_inputs();
        bus.rf_hold = 1'b0;
        chk("wrap_total", got, 10);

        // reset mid-operation at count 3
        bus.rf_hold = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_dst = 4'd7; bus.mem_data = 16'h0707;
        bus.alu_valid = 1'b1; bus.alu_dst = 4'd8; bus.alu_data = 16'h0808;
        step();
        bus.mem_valid = 1'b0;
        bus.alu_dst = 4'd9; bus.alu_data = 16'h0909;
        step();
        idle_inputs();
        #1;
        chk("mid_count3", bus.count,    3);
        chk("mid_ready3", bus.in_ready, 0);
        rst = 1'b1;
        bus.rf_hold = 1'b0;
        #1;
        chk("mid_rst_we", bus.rf_we, 0);
        step();
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_we2",   bus.rf_we, 0);
        rst = 1'b0;
        #1;
        chk("mid_ready_after", bus.in_ready, 1);
        chk("mid_count_after", bus.count,    0);
        chk("mid_we_after",    bus.rf_we,    0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
